// File: rtl/plot_sequencer.sv
// -----------------------------------------------------------------------------
// plot_sequencer
//   Draw sequencer for the VGA plot path. It emits one pixel per cycle
//   (x, y, colour, plot) towards vga_adapter.
//
//   Game flow:
//   - A start pulse clears the screen with a raster sweep.
//   - Play then repeats rounds. Each round draws every player position and
//     then one timer-bar pixel.
//   - When the bar-length game timer expires, the current round finishes.
//     The screen is cleared again and a filled box is drawn in the winner's
//     colour.
//
// Ports
//   CLOCK_50      in  system clock, rising edge
//   reset         in  synchronous active-high reset
//   start         in  1-cycle pulse, starts a new game (IDLE/DONE only)
//   timer_tick    in  1-cycle pulse, advances the game timer while running
//   player_pos    in  packed {x,y} per player, player i at [i*POS_W +: POS_W]
//   player_colour in  3-bit colour per player, player i at [i*3 +: 3]
//   winner        in  winning player index, latched when the final clear begins
//   x, y, colour  out pixel to write
//   plot          out pixel valid strobe, one cycle per pixel
//   running       out game in progress
//   game_over     out winner box finished, held until start/reset
// -----------------------------------------------------------------------------
module plot_sequencer #(
   parameter int NUM_PLAYERS = 4,
   parameter int X_W         = 8,
   parameter int Y_W         = 7,
   parameter int X_MAX       = 159,
   parameter int Y_MAX       = 119,
   parameter int TIMER_Y     = 119,
   parameter int TIMER_LEN   = 159,
   parameter int BOX_X       = 76,
   parameter int BOX_Y       = 55,
   parameter int BOX_W       = 8,
   parameter int BOX_H       = 8
) (
   input  logic                               CLOCK_50,
   input  logic                               reset,
   input  logic                               start,
   input  logic                               timer_tick,
   input  logic [NUM_PLAYERS*(X_W+Y_W)-1:0]   player_pos,
   input  logic [NUM_PLAYERS*3-1:0]           player_colour,
   input  logic [2:0]                         winner,
   output logic [X_W-1:0]                     x,
   output logic [Y_W-1:0]                     y,
   output logic [2:0]                         colour,
   output logic                               plot,
   output logic                               running,
   output logic                               game_over
);

   localparam int POS_W = X_W + Y_W;

   localparam logic [X_W-1:0] X_LAST_C    = X_W'(X_MAX);
   localparam logic [Y_W-1:0] Y_LAST_C    = Y_W'(Y_MAX);
   localparam logic [Y_W-1:0] TIMER_Y_C   = Y_W'(TIMER_Y);
   localparam logic [X_W-1:0] TLEN_C      = X_W'(TIMER_LEN);
   localparam logic [X_W-1:0] TLEN_M1_C   = X_W'(TIMER_LEN - 1);
   localparam logic [X_W-1:0] BOX_X_C     = X_W'(BOX_X);
   localparam logic [Y_W-1:0] BOX_Y_C     = Y_W'(BOX_Y);
   localparam logic [X_W-1:0] BOX_X_LAST_C = X_W'(BOX_W - 1);
   localparam logic [Y_W-1:0] BOX_Y_LAST_C = Y_W'(BOX_H - 1);
   localparam logic [3:0]     IDX_LAST_C  = 4'(NUM_PLAYERS - 1);
   localparam logic [X_W-1:0] X_ONE_C     = X_W'(1);
   localparam logic [Y_W-1:0] Y_ONE_C     = Y_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PRECLEAR = 3'd1,
      ST_PLAYERS  = 3'd2,
      ST_TIMER    = 3'd3,
      ST_CLEAR    = 3'd4,
      ST_WINNER   = 3'd5,
      ST_DONE     = 3'd6
   } state_t;

   state_t           state_r;
   logic [X_W-1:0]   sweep_x_r;
   logic [Y_W-1:0]   sweep_y_r;
   logic [3:0]       idx_r;
   logic [X_W-1:0]   box_x_r;
   logic [Y_W-1:0]   box_y_r;
   logic [X_W-1:0]   count_r;
   logic [2:0]       win_r;

   logic [POS_W-1:0] cur_pos_s;
   logic [2:0]       cur_col_s;
   logic [2:0]       win_col_s;

   // Position of player idx. The loop is a plain mux, so no index can go out of range.
   function automatic logic [POS_W-1:0] pos_of(input logic [3:0] idx,
                                               input logic [NUM_PLAYERS*POS_W-1:0] pos);
      logic [POS_W-1:0] p;
      p = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (idx == 4'(i)) begin
            p = pos[i*POS_W +: POS_W];
         end
      end
      return p;
   endfunction

   // Colour of player idx. An index with no matching player gives white (111).
   function automatic logic [2:0] colour_of(input logic [3:0] idx,
                                            input logic [NUM_PLAYERS*3-1:0] cols);
      logic [2:0] c;
      c = 3'b111;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (idx == 4'(i)) begin
            c = cols[i*3 +: 3];
         end
      end
      return c;
   endfunction

   assign cur_pos_s = pos_of(idx_r, player_pos);
   assign cur_col_s = colour_of(idx_r, player_colour);
   assign win_col_s = colour_of({1'b0, win_r}, player_colour);

   // Sequencer state machine, registered pixel outputs and game timer
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         x         <= '0;
         y         <= '0;
         colour    <= 3'b000;
         plot      <= 1'b0;
         running   <= 1'b0;
         game_over <= 1'b0;
         count_r   <= '0;
         win_r     <= 3'd0;
         sweep_x_r <= '0;
         sweep_y_r <= '0;
         idx_r     <= 4'd0;
         box_x_r   <= '0;
         box_y_r   <= '0;
      end else begin
         plot <= 1'b0;

         // The timer runs independently of the draw state. The expiring tick
         // only clears running. The round in progress still completes.
         if (running && timer_tick) begin
            if (count_r < TLEN_M1_C) begin
               count_r <= count_r + X_ONE_C;
            end else begin
               count_r <= TLEN_C;
               running <= 1'b0;
            end
         end

         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  count_r   <= '0;
                  game_over <= 1'b0;
                  sweep_x_r <= '0;
                  sweep_y_r <= '0;
                  state_r   <= ST_PRECLEAR;
               end else if (state_r == ST_DONE) begin
                  game_over <= 1'b1;
               end
            end

            ST_PRECLEAR, ST_CLEAR: begin
               x      <= sweep_x_r;
               y      <= sweep_y_r;
               colour <= 3'b000;
               plot   <= 1'b1;
               if (sweep_x_r == X_LAST_C) begin
                  sweep_x_r <= '0;
                  if (sweep_y_r == Y_LAST_C) begin
                     sweep_y_r <= '0;
                     if (state_r == ST_PRECLEAR) begin
                        running <= 1'b1;
                        idx_r   <= 4'd0;
                        state_r <= ST_PLAYERS;
                     end else begin
                        box_x_r <= '0;
                        box_y_r <= '0;
                        state_r <= ST_WINNER;
                     end
                  end else begin
                     sweep_y_r <= sweep_y_r + Y_ONE_C;
                  end
               end else begin
                  sweep_x_r <= sweep_x_r + X_ONE_C;
               end
            end

            ST_PLAYERS: begin
               x      <= cur_pos_s[POS_W-1:Y_W];
               y      <= cur_pos_s[Y_W-1:0];
               colour <= cur_col_s;
               plot   <= 1'b1;
               if (idx_r == IDX_LAST_C) begin
                  idx_r   <= 4'd0;
                  state_r <= ST_TIMER;
               end else begin
                  idx_r <= idx_r + 4'd1;
               end
            end

            ST_TIMER: begin
               // The bar grows one pixel per tick. Once the timer is full, nothing is plotted.
               if (count_r < TLEN_C) begin
                  x      <= count_r;
                  y      <= TIMER_Y_C;
                  colour <= 3'b111;
                  plot   <= 1'b1;
               end
               if (running) begin
                  state_r <= ST_PLAYERS;
               end else begin
                  win_r     <= winner;
                  sweep_x_r <= '0;
                  sweep_y_r <= '0;
                  state_r   <= ST_CLEAR;
               end
            end

            ST_WINNER: begin
               x      <= BOX_X_C + box_x_r;
               y      <= BOX_Y_C + box_y_r;
               colour <= win_col_s;
               plot   <= 1'b1;
               if (box_x_r == BOX_X_LAST_C) begin
                  box_x_r <= '0;
                  if (box_y_r == BOX_Y_LAST_C) begin
                     box_y_r <= '0;
                     state_r <= ST_DONE;
                  end else begin
                     box_y_r <= box_y_r + Y_ONE_C;
                  end
               end else begin
                  box_x_r <= box_x_r + X_ONE_C;
               end
            end

            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_plot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_plot_sequencer
//   Randomised self-checking bench for plot_sequencer.
//
//   Expected pixels come from the game rules:
//   - raster order for the clears;
//   - the player list followed by the bar pixel for each round;
//   - a tick tally that ends the game;
//   - the box scan with the latched winner's colour.
//
//   A second instance with default parameters checks the full-screen clear length.
// -----------------------------------------------------------------------------
module tb_plot_sequencer;

   localparam int P   = 2;
   localparam int XM  = 3;
   localparam int YM  = 2;
   localparam int TY  = 2;
   localparam int LEN = 3;
   localparam int BX  = 1;
   localparam int BY  = 1;
   localparam int BW  = 2;
   localparam int BH  = 2;
   localparam int N   = (XM + 1) * (YM + 1);

   logic              CLOCK_50 = 1'b0;
   logic              reset, start, timer_tick;
   logic [P*15-1:0]   player_pos;
   logic [P*3-1:0]    player_colour;
   logic [2:0]        winner;
   logic [7:0]        x;
   logic [6:0]        y;
   logic [2:0]        colour;
   logic              plot, running, game_over;

   logic              reset2, start2;
   logic              tick2 = 1'b0;
   logic [4*15-1:0]   pos2 = '0;
   logic [11:0]       col2 = '0;
   logic [2:0]        win2 = 3'd0;
   logic [7:0]        x2;
   logic [6:0]        y2;
   logic [2:0]        colour2;
   logic              plot2, running2, game_over2;

   int n_compared   = 0;
   int n_mismatched = 0;

   plot_sequencer #(
      .NUM_PLAYERS(P), .X_W(8), .Y_W(7), .X_MAX(XM), .Y_MAX(YM), .TIMER_Y(TY),
      .TIMER_LEN(LEN), .BOX_X(BX), .BOX_Y(BY), .BOX_W(BW), .BOX_H(BH)
   ) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .timer_tick(timer_tick),
      .player_pos(player_pos), .player_colour(player_colour), .winner(winner),
      .x(x), .y(y), .colour(colour), .plot(plot), .running(running), .game_over(game_over)
   );

   plot_sequencer dut_dflt (
      .CLOCK_50(CLOCK_50), .reset(reset2), .start(start2), .timer_tick(tick2),
      .player_pos(pos2), .player_colour(col2), .winner(win2),
      .x(x2), .y(y2), .colour(colour2), .plot(plot2), .running(running2), .game_over(game_over2)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Bound the whole run in case the design stalls.
   initial begin
      #5000000;
      $display("FAIL watchdog: observed no finish, required finish before time limit");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: observed %0h required %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick_clk();
      @(posedge CLOCK_50);
      #1;
   endtask

   function automatic logic [31:0] pix(input logic p, input logic [7:0] px,
                                       input logic [6:0] py, input logic [2:0] pc);
      return {13'd0, p, px, py, pc};
   endfunction

   function automatic logic [31:0] obs_pix();
      return {13'd0, plot, x, y, colour};
   endfunction

   // Raster sweep check. Start, ticks and winner are randomised, and all are ignored here.
   task automatic sweep_check(input bit is_pre, input int abort_at, output bit aborted);
      aborted = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (k == abort_at) begin
            start = 1'b0; timer_tick = 1'b1; reset = 1'b1;
            tick_clk();
            check_eq("abort_plot", 32'(plot), 32'd0);
            check_eq("abort_run", 32'(running), 32'd0);
            check_eq("abort_gover", 32'(game_over), 32'd0);
            reset = 1'b0; timer_tick = 1'b0;
            tick_clk();
            check_eq("abort_idle_plot", 32'(plot), 32'd0);
            tick_clk();
            check_eq("abort_idle_plot2", 32'(plot), 32'd0);
            aborted = 1'b1;
            break;
         end
         start         = ($urandom_range(0, 3) == 0);
         timer_tick    = 1'($urandom_range(0, 1));
         winner        = 3'($urandom_range(0, 7));
         player_colour = 6'($urandom);
         tick_clk();
         check_eq(is_pre ? "preclear_px" : "clear_px", obs_pix(),
                  pix(1'b1, 8'(k % (XM + 1)), 7'(k / (XM + 1)), 3'b000));
         check_eq(is_pre ? "preclear_run" : "clear_run", 32'(running),
                  32'((is_pre && k == N - 1) ? 1 : 0));
      end
      start = 1'b0; timer_tick = 1'b0;
   endtask

   task automatic run_game(input int quiet_rounds, input int force_win, input int abort_at);
      int         cnt;
      bit         mrun;
      int         rounds;
      logic [2:0] win_l;
      logic [2:0] exp_c;
      bit         aborted;

      // Start and a tick arrive in the same cycle. The count must still begin at zero.
      start = 1'b1; timer_tick = 1'b1;
      tick_clk();
      start = 1'b0; timer_tick = 1'b0;
      check_eq("start_plot", 32'(plot), 32'd0);
      check_eq("start_gover", 32'(game_over), 32'd0);

      sweep_check(1'b1, -1, aborted);

      cnt = 0; mrun = 1'b1; rounds = 0; win_l = 3'd0;
      while (mrun && rounds < 200) begin
         for (int p = 0; p < P; p++) begin
            if (rounds < quiet_rounds) begin
               player_pos    = {8'd7, 7'd1, 8'd5, 7'd6};
               player_colour = {3'b010, 3'b001};
               timer_tick    = 1'b0;
               start         = 1'b0;
            end else begin
               player_pos    = 30'({$urandom, $urandom});
               player_colour = 6'($urandom);
               timer_tick    = ($urandom_range(0, 2) == 0);
               start         = 1'($urandom_range(0, 1));
            end
            tick_clk();
            check_eq("player_px", obs_pix(),
                     pix(1'b1, player_pos[p*15+7 +: 8], player_pos[p*15 +: 7], player_colour[p*3 +: 3]));
            if (timer_tick && mrun) begin
               cnt++;
               if (cnt == LEN) mrun = 1'b0;
            end
            check_eq("play_run", 32'(running), 32'(mrun));
         end
         start = 1'b0; timer_tick = 1'b0;
         winner = (force_win >= 0) ? 3'(force_win) : 3'($urandom_range(0, 7));
         win_l = winner;
         tick_clk();
         if (cnt < LEN) check_eq("bar_px", obs_pix(), pix(1'b1, 8'(cnt), 7'(TY), 3'b111));
         else           check_eq("bar_off", 32'(plot), 32'd0);
         rounds++;
      end
      check_eq("round_bound", 32'(rounds < 200), 32'd1);

      sweep_check(1'b0, abort_at, aborted);
      if (!aborted) begin
         for (int k = 0; k < BW * BH; k++) begin
            player_colour = 6'($urandom);
            winner        = 3'($urandom_range(0, 7));
            tick_clk();
            exp_c = (int'(win_l) < P) ? player_colour[int'(win_l)*3 +: 3] : 3'b111;
            check_eq("box_px", obs_pix(), pix(1'b1, 8'(BX + k % BW), 7'(BY + k / BW), exp_c));
         end
         tick_clk();
         check_eq("done_plot", 32'(plot), 32'd0);
         tick_clk();
         check_eq("done_gover", 32'(game_over), 32'd1);
         check_eq("done_plot2", 32'(plot), 32'd0);
         check_eq("done_run", 32'(running), 32'd0);
      end
   endtask

   initial begin
      int n_pix;
      int t;

      reset = 1'b1; start = 1'b0; timer_tick = 1'b0;
      player_pos = '0; player_colour = '0; winner = 3'd0;
      reset2 = 1'b1; start2 = 1'b0;
      tick_clk();
      tick_clk();
      check_eq("rst_px", obs_pix(), pix(1'b0, 8'd0, 7'd0, 3'd0));
      check_eq("rst_run", 32'(running), 32'd0);
      check_eq("rst_gover", 32'(game_over), 32'd0);

      // A start pulse while reset is held must not begin a game.
      start = 1'b1;
      tick_clk();
      start = 1'b0; reset = 1'b0;
      tick_clk();
      check_eq("idle_plot", 32'(plot), 32'd0);
      tick_clk();
      check_eq("idle_plot2", 32'(plot), 32'd0);
      check_eq("idle_run", 32'(running), 32'd0);

      run_game(3, 1, -1);
      run_game(0, 5, -1);
      run_game(0, -1, 5);
      for (int g = 0; g < 5; g++) run_game(0, -1, -1);

      // Default-size instance: the full-screen pre-clear takes 160*120 plotted cycles.
      reset2 = 1'b0;
      tick_clk();
      start2 = 1'b1;
      tick_clk();
      start2 = 1'b0;
      n_pix = 0; t = 0;
      while (running2 !== 1'b1 && t < 20000) begin
         tick_clk();
         t++;
         if (plot2) n_pix++;
      end
      check_eq("dflt_pre_pixels", 32'(n_pix), 32'd19200);
      check_eq("dflt_pre_cycles", 32'(t), 32'd19200);
      check_eq("dflt_running", 32'(running2), 32'd1);
      check_eq("dflt_last_px", {17'd0, x2, y2}, {17'd0, 8'd159, 7'd119});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
